// File: rtl/cacheline_adaptor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cacheline_adaptor
// Description : Converts single-handshake cache line reads/writes into
//               multi-beat memory bursts and reassembles read beats.
// Revision    : 1.0 - initial release
// ============================================================================
module cacheline_adaptor #(
    parameter int BURST_WIDTH = 64,
    parameter int BURSTS      = 4,
    parameter int LINE_WIDTH  = 256,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    input  logic [ADDR_WIDTH-1:0]  address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    output logic                   resp_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    output logic [ADDR_WIDTH-1:0]  address_o,
    output logic                   read_o,
    output logic                   write_o,
    input  logic                   resp_i
);

    localparam int c_cnt_w    = (BURSTS > 1) ? $clog2(BURSTS) : 1;
    localparam int c_offset_w = $clog2(LINE_WIDTH / 8);
    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(BURSTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                             state_q, state_d;
    logic [c_cnt_w-1:0]                 cnt_q, cnt_d;
    logic [ADDR_WIDTH-c_offset_w-1:0]   addr_q, addr_d;
    logic [LINE_WIDTH-1:0]              buf_q, buf_d;
    logic [LINE_WIDTH-1:0]              line_q, line_d;

    logic w_last_beat;
    logic w_unused_offset;

    assign w_last_beat     = (cnt_q == c_last_beat);
    assign w_unused_offset = ^address_i[c_offset_w-1:0];

    // One buffer serves both directions: write data while in WR, beat assembly while in RD.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        buf_d   = buf_q;
        line_d  = line_q;
        case (state_q)
            ST_IDLE: begin
                if (read_i) begin
                    addr_d  = address_i[ADDR_WIDTH-1:c_offset_w];
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RD;
                end else if (write_i) begin
                    addr_d  = address_i[ADDR_WIDTH-1:c_offset_w];
                    buf_d   = line_i;
                    cnt_d   = '0;
                    state_d = ST_WR;
                end
            end
            ST_RD: begin
                if (resp_i) begin
                    for (int k = 0; k < BURSTS; k++) begin
                        if (cnt_q == c_cnt_w'(k)) begin
                            buf_d[k*BURST_WIDTH +: BURST_WIDTH] = burst_i;
                        end
                    end
                    if (w_last_beat) begin
                        cnt_d   = '0;
                        line_d  = buf_d;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_WR: begin
                if (resp_i) begin
                    if (w_last_beat) begin
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            buf_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            line_q  <= line_d;
        end
    end

    // Outputs depend only on registered state, never on inputs directly.
    always_comb begin
        read_o    = (state_q == ST_RD);
        write_o   = (state_q == ST_WR);
        resp_o    = (state_q == ST_DONE);
        line_o    = line_q;
        address_o = '0;
        burst_o   = '0;
        if ((state_q == ST_RD) || (state_q == ST_WR)) begin
            address_o = {addr_q, {c_offset_w{1'b0}}};
        end
        if (state_q == ST_WR) begin
            for (int k = 0; k < BURSTS; k++) begin
                if (cnt_q == c_cnt_w'(k)) begin
                    burst_o = buf_q[k*BURST_WIDTH +: BURST_WIDTH];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cacheline_adaptor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cacheline_adaptor
// Description : Directed vector table plus hand-written burst sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cacheline_adaptor;

    localparam int BW = 64;
    localparam int NB = 4;
    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [LW-1:0] line_i;
    logic [LW-1:0] line_o;
    logic [AW-1:0] address_i;
    logic          read_i;
    logic          write_i;
    logic          resp_o;
    logic [BW-1:0] burst_i;
    logic [BW-1:0] burst_o;
    logic [AW-1:0] address_o;
    logic          read_o;
    logic          write_o;
    logic          resp_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cacheline_adaptor #(
        .BURST_WIDTH (BW),
        .BURSTS      (NB),
        .LINE_WIDTH  (LW),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    typedef struct packed {
        logic          rd;
        logic          wr;
        logic          rsp;
        logic [BW-1:0] bi;
        logic          rdo;
        logic          wro;
        logic          rso;
        logic [AW-1:0] ao;
        logic          cl;
        logic [LW-1:0] ln;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rd, input logic wr, input logic rsp,
                                input logic [BW-1:0] bi, input logic rdo,
                                input logic wro, input logic rso,
                                input logic [AW-1:0] ao, input logic cl,
                                input logic [LW-1:0] ln);
        vec_t v;
        v.rd = rd; v.wr = wr; v.rsp = rsp; v.bi = bi;
        v.rdo = rdo; v.wro = wro; v.rso = rso; v.ao = ao;
        v.cl = cl; v.ln = ln;
        return v;
    endfunction

    function automatic logic [BW-1:0] rep(input logic [3:0] n);
        return {16{n}};
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic rdo, input logic wro,
                              input logic rso, input logic [AW-1:0] ao,
                              input logic [BW-1:0] bo);
        chk({tag, " read_o"},    LW'(read_o),    LW'(rdo));
        chk({tag, " write_o"},   LW'(write_o),   LW'(wro));
        chk({tag, " resp_o"},    LW'(resp_o),    LW'(rso));
        chk({tag, " address_o"}, LW'(address_o), LW'(ao));
        chk({tag, " burst_o"},   LW'(burst_o),   LW'(bo));
    endtask

    // Entered in the first RD window with read_i already held high.
    task automatic run_read(input string tag, input logic [AW-1:0] aexp, input logic [LW-1:0] data);
        for (int k = 0; k < NB; k++) begin
            check_outs($sformatf("%s beat%0d", tag, k), 1'b1, 1'b0, 1'b0, aexp, '0);
            resp_i  = 1'b1;
            burst_i = data[k*BW +: BW];
            tick();
        end
        resp_i  = 1'b0;
        burst_i = '0;
        check_outs({tag, " done"}, 1'b0, 1'b0, 1'b1, '0, '0);
        chk({tag, " line_o done"}, line_o, data);
        read_i = 1'b0;
        tick();
        check_outs({tag, " idle"}, 1'b0, 1'b0, 1'b0, '0, '0);
        chk({tag, " line_o idle"}, line_o, data);
    endtask

    initial begin
        logic [LW-1:0] r1, r2, r3, wl, rg, ljunk;
        logic [AW-1:0] a60;
        logic [AW-1:0] awr;

        r1    = {rep(4'h4), rep(4'h3), rep(4'h2), rep(4'h1)};
        r2    = {rep(4'h8), rep(4'h7), rep(4'h6), rep(4'h5)};
        r3    = {64'hCAFE_F00D_0000_0002, 64'hDEAD_BEEF_0000_0001,
                 64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
        wl    = {rep(4'hD), rep(4'hC), rep(4'hB), rep(4'hA)};
        rg    = {rep(4'hC), rep(4'hB), rep(4'hA), rep(4'h9)};
        ljunk = {4{64'h5A5A_A5A5_0F0F_F0F0}};
        a60   = 32'h0000_0060;
        awr   = 32'h0000_ABE0;

        // Read with back-to-back beats, then a simultaneous read+write request.
        vecs.push_back(mk(1,0,0,'0,            0,0,0,'0, 0,'0));
        vecs.push_back(mk(1,0,1,rep(4'h1),     1,0,0,a60,0,'0));
        vecs.push_back(mk(1,0,1,rep(4'h2),     1,0,0,a60,0,'0));
        vecs.push_back(mk(1,0,1,rep(4'h3),     1,0,0,a60,0,'0));
        vecs.push_back(mk(1,0,1,rep(4'h4),     1,0,0,a60,0,'0));
        vecs.push_back(mk(0,0,0,'0,            0,0,1,'0, 1,r1));
        vecs.push_back(mk(1,1,0,'0,            0,0,0,'0, 1,r1));
        vecs.push_back(mk(1,1,1,rep(4'h5),     1,0,0,a60,1,r1));
        vecs.push_back(mk(1,1,1,rep(4'h6),     1,0,0,a60,1,r1));
        vecs.push_back(mk(1,1,1,rep(4'h7),     1,0,0,a60,1,r1));
        vecs.push_back(mk(1,1,1,rep(4'h8),     1,0,0,a60,1,r1));
        vecs.push_back(mk(0,0,0,'0,            0,0,1,'0, 1,r2));
        // Spurious beats while idle must not advance the beat counter.
        vecs.push_back(mk(0,0,1,rep(4'hE),     0,0,0,'0, 1,r2));
        vecs.push_back(mk(0,0,1,rep(4'hF),     0,0,0,'0, 1,r2));
        vecs.push_back(mk(1,0,0,'0,            0,0,0,'0, 1,r2));
        vecs.push_back(mk(1,0,1,r3[63:0],      1,0,0,a60,1,r2));
        vecs.push_back(mk(1,0,1,r3[127:64],    1,0,0,a60,1,r2));
        vecs.push_back(mk(1,0,1,r3[191:128],   1,0,0,a60,1,r2));
        vecs.push_back(mk(1,0,1,r3[255:192],   1,0,0,a60,1,r2));
        vecs.push_back(mk(0,0,1,rep(4'hE),     0,0,1,'0, 1,r3));
        vecs.push_back(mk(0,0,0,'0,            0,0,0,'0, 1,r3));
        vecs.push_back(mk(0,0,0,'0,            0,0,0,'0, 1,r3));

        rst       = 1'b0;
        line_i    = '0;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = '0;
        resp_i    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 1'b0, 1'b0, 1'b0, '0, '0);
        chk("reset line_o", line_o, '0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        address_i = 32'h0000_0064;
        line_i    = ljunk;
        foreach (vecs[i]) begin
            check_outs($sformatf("vec%0d", i), vecs[i].rdo, vecs[i].wro, vecs[i].rso, vecs[i].ao, '0);
            if (vecs[i].cl) chk($sformatf("vec%0d line_o", i), line_o, vecs[i].ln);
            read_i  = vecs[i].rd;
            write_i = vecs[i].wr;
            resp_i  = vecs[i].rsp;
            burst_i = vecs[i].bi;
            tick();
        end

        // Write with two idle cycles before every beat strobe.
        address_i = 32'h0000_ABFF;
        line_i    = wl;
        write_i   = 1'b1;
        check_outs("wr req", 1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        for (int k = 0; k < NB; k++) begin
            for (int g = 0; g < 3; g++) begin
                resp_i = (g == 2);
                check_outs($sformatf("wr beat%0d g%0d", k, g), 1'b0, 1'b1, 1'b0, awr, wl[k*BW +: BW]);
                tick();
            end
        end
        resp_i = 1'b0;
        check_outs("wr done", 1'b0, 1'b0, 1'b1, '0, '0);
        chk("wr line_o kept", line_o, r3);
        write_i = 1'b0;
        line_i  = ljunk;
        tick();
        // The single idle cycle after DONE, with the next read presented at once.
        check_outs("wr idle", 1'b0, 1'b0, 1'b0, '0, '0);
        address_i = 32'h0000_0064;
        read_i    = 1'b1;
        tick();
        run_read("rd after wr", a60, r1);

        // Asynchronous reset in the middle of a read, after two beats.
        address_i = 32'h0000_0164;
        read_i    = 1'b1;
        tick();
        resp_i  = 1'b1;
        burst_i = rep(4'hD);
        tick();
        burst_i = rep(4'hE);
        tick();
        resp_i  = 1'b0;
        burst_i = '0;
        check_outs("pre abort", 1'b1, 1'b0, 1'b0, 32'h0000_0160, '0);
        #2;
        rst = 1'b0;
        #1;
        check_outs("abort", 1'b0, 1'b0, 1'b0, '0, '0);
        chk("abort line_o", line_o, '0);
        read_i = 1'b0;
        @(posedge clk);
        #1;
        check_outs("abort hold", 1'b0, 1'b0, 1'b0, '0, '0);
        #2;
        rst = 1'b1;
        tick();
        check_outs("post abort idle", 1'b0, 1'b0, 1'b0, '0, '0);
        read_i = 1'b1;
        tick();
        run_read("rd after abort", 32'h0000_0160, rg);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
